// File: rtl/stopwatch_pkg.sv
// -----------------------------------------------------------------------------
// stopwatch_pkg
// Shared types and constants for the BCD stopwatch/timer core.
//   state_e    : run/pause FSM states (IDLE, RUN, EXPIRED, ADJUST)
//   BCD_W      : width of one BCD digit
//   MOD_UNITS  : modulus of even-index digits (seconds/minutes/hours units)
//   MOD_TENS   : modulus of odd-index digits (tens)
//   digit_mod  : modulus of digit i, chosen by index parity
// -----------------------------------------------------------------------------
package stopwatch_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    EXPIRED = 2'd2,
    ADJUST  = 2'd3
  } state_e;

  localparam int BCD_W     = 4;
  localparam int MOD_UNITS = 10;
  localparam int MOD_TENS  = 6;

  // Digits pair up as (units, tens) from the LSB: SS, MM, HH, ...
  function automatic int digit_mod(input int idx);
    return ((idx % 2) == 0) ? MOD_UNITS : MOD_TENS;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit
// One modulo-MOD BCD digit register with clear, clamped load, increment and
// decrement. Priority: rst > clr > load > inc > dec.
// The digit modulus is 10 for units digits and 6 for tens digits.
// Ports:
//   clk      : system clock
//   rst      : synchronous active-high reset, digit -> 0
//   clr      : synchronous clear, digit -> 0
//   load     : write load_val (clamped to the digit maximum)
//   load_val : BCD value to load
//   inc      : increment, maximum rolls to 0
//   dec      : decrement, 0 rolls to maximum
//   q        : current digit value
//   at_max   : q at digit maximum (carry-out condition for up count)
//   at_zero  : q == 0 (borrow-out condition for down count)
// -----------------------------------------------------------------------------
module bcd_digit
  import stopwatch_pkg::*;
#(
  parameter int MOD = MOD_UNITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             load,
  input  logic [BCD_W-1:0] load_val,
  input  logic             inc,
  input  logic             dec,
  output logic [BCD_W-1:0] q,
  output logic             at_max,
  output logic             at_zero
);

  localparam logic [BCD_W-1:0] MAX_VAL = BCD_W'(MOD - 1);

  logic [BCD_W-1:0] q_q;
  logic [BCD_W-1:0] q_d;
  logic [BCD_W-1:0] load_clamped;

  // Out-of-range loads saturate at the digit maximum rather than wrapping.
  assign load_clamped = (load_val > MAX_VAL) ? MAX_VAL : load_val;

  always_comb begin
    q_d = q_q;
    if (clr) begin
      q_d = '0;
    end else if (load) begin
      q_d = load_clamped;
    end else if (inc) begin
      q_d = (q_q >= MAX_VAL) ? '0 : q_q + 1'b1;
    end else if (dec) begin
      q_d = (q_q == '0) ? MAX_VAL : q_q - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q_q <= '0;
    end else begin
      q_q <= q_d;
    end
  end

  assign q       = q_q;
  assign at_max  = (q_q == MAX_VAL);
  assign at_zero = (q_q == '0);

endmodule

// File: rtl/bcd_timer_core.sv
// -----------------------------------------------------------------------------
// bcd_timer_core
// Parametrised stopwatch/timer core: DIGITS BCD digits arranged as
// (units mod 10, tens mod 6) pairs from the LSB, counting up or down on tick,
// with a run/pause FSM, count-down expiry and clamped per-digit adjust.
//
// Parameters:
//   DIGITS     : number of BCD digits (even, >= 2)
//   SELW       : width of adj_sel
// Ports:
//   clk        : system clock
//   rst        : synchronous active-high reset (overrides everything)
//   tick       : one-clk count enable
//   run_toggle : start/pause pulse
//   clear      : zero all digits; to IDLE (stays ADJUST when adjusting)
//   down       : 1 = count down, 0 = count up
//   adj        : adjust mode level
//   adj_sel    : digit index to load (0 = LSB); indices >= DIGITS ignored
//   adj_val    : BCD value to load (clamped to digit maximum)
//   adj_load   : load pulse
//   digits     : BCD digits, digit i at [4i+3:4i]
//   running    : high while in RUN
//   expired    : high while in EXPIRED
//   wrap       : one-cycle pulse when an up count rolls all digits to zero
// Optional (macro LAP_EN):
//   lap        : capture pulse (accepted in RUN or IDLE)
//   lap_digits : captured digits (value before any coincident tick)
//   lap_valid  : set on capture, cleared by rst/clear
// -----------------------------------------------------------------------------
module bcd_timer_core
  import stopwatch_pkg::*;
#(
  parameter int DIGITS = 4,
  parameter int SELW   = $clog2(DIGITS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    tick,
  input  logic                    run_toggle,
  input  logic                    clear,
  input  logic                    down,
  input  logic                    adj,
  input  logic [SELW-1:0]         adj_sel,
  input  logic [BCD_W-1:0]        adj_val,
  input  logic                    adj_load,
`ifdef LAP_EN
  input  logic                    lap,
  output logic [BCD_W*DIGITS-1:0] lap_digits,
  output logic                    lap_valid,
`endif
  output logic [BCD_W*DIGITS-1:0] digits,
  output logic                    running,
  output logic                    expired,
  output logic                    wrap
);

  state_e state_q;
  state_e state_d;

  logic running_q;
  logic expired_q;
  logic wrap_q;
  logic wrap_d;

  logic [DIGITS-1:0] at_max;
  logic [DIGITS-1:0] at_zero;
  logic [DIGITS-1:0] dig_inc;
  logic [DIGITS-1:0] dig_dec;
  logic [DIGITS-1:0] dig_load;
  logic [DIGITS-1:0] low_max;
  logic [DIGITS-1:0] low_zero;

  logic all_max;
  logic all_zero;
  logic one_left;
  logic count_en;
  logic up_tick;
  logic down_tick;
  logic load_en;

  // A tick only counts in RUN and only if nothing of higher priority
  // (clear, adj) claims the cycle; rst is handled by the registers.
  assign count_en  = (state_q == RUN) && tick && !clear && !adj;
  assign up_tick   = count_en && !down;
  assign down_tick = count_en && down;

  // Loads are accepted only while resident in ADJUST with adj still held.
  assign load_en = (state_q == ADJUST) && adj && adj_load && !clear;

  assign all_max  = &at_max;
  assign all_zero = &at_zero;

  // Count value is exactly 0..01, so the coming down tick reaches zero.
  assign one_left = (digits[BCD_W-1:0] == BCD_W'(1)) && (&at_zero[DIGITS-1:1]);

  // ---------------------------------------------------------------------------
  // Digit array with ripple carry/borrow. Each digit steps when every lower
  // digit is at its max (up) or zero (down).
  // ---------------------------------------------------------------------------
  for (genvar gi = 0; gi < DIGITS; gi++) begin : g_digit
    if (gi == 0) begin : g_lsb
      assign low_max[gi]  = 1'b1;
      assign low_zero[gi] = 1'b1;
    end else begin : g_upper
      assign low_max[gi]  = &at_max[gi-1:0];
      assign low_zero[gi] = &at_zero[gi-1:0];
    end

    assign dig_inc[gi]  = up_tick && low_max[gi];
    assign dig_dec[gi]  = down_tick && low_zero[gi];
    // SELW may exceed the index range; out-of-range selects match no digit.
    assign dig_load[gi] = load_en && (adj_sel == SELW'(gi));

    bcd_digit #(
      .MOD(digit_mod(gi))
    ) u_digit (
      .clk     (clk),
      .rst     (rst),
      .clr     (clear),
      .load    (dig_load[gi]),
      .load_val(adj_val),
      .inc     (dig_inc[gi]),
      .dec     (dig_dec[gi]),
      .q       (digits[gi*BCD_W +: BCD_W]),
      .at_max  (at_max[gi]),
      .at_zero (at_zero[gi])
    );
  end

  // ---------------------------------------------------------------------------
  // Run/pause FSM. Priority: clear > adj > run_toggle > tick, except that in
  // RUN a tick and run_toggle in the same cycle both take effect.
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d = state_q;
    wrap_d  = 1'b0;

    if (clear) begin
      state_d = (state_q == ADJUST) ? ADJUST : IDLE;
    end else if (adj) begin
      state_d = ADJUST;
    end else begin
      case (state_q)
        IDLE: begin
          // A zero count-down timer has nothing to run.
          if (run_toggle && !(down && all_zero)) begin
            state_d = RUN;
          end
        end
        RUN: begin
          if (up_tick && all_max) begin
            wrap_d = 1'b1;
          end
          // The coincident toggle pauses after the count; a timer that
          // expires on that tick ends up paused as well.
          if (run_toggle) begin
            state_d = IDLE;
          end else if (down_tick && one_left) begin
            state_d = EXPIRED;
          end
        end
        EXPIRED: begin
          if (run_toggle) begin
            state_d = IDLE;
          end
        end
        ADJUST: begin
          state_d = IDLE;
        end
        default: begin
          state_d = IDLE;
        end
      endcase
    end
  end

  // Status flags decode the next state so they line up with state_q.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      running_q <= 1'b0;
      expired_q <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      running_q <= (state_d == RUN);
      expired_q <= (state_d == EXPIRED);
      wrap_q    <= wrap_d;
    end
  end

  assign running = running_q;
  assign expired = expired_q;
  assign wrap    = wrap_q;

`ifdef LAP_EN
  // ---------------------------------------------------------------------------
  // Lap capture: snapshot of the digits as they stand this cycle, i.e. before
  // any coincident tick lands.
  // ---------------------------------------------------------------------------
  logic [BCD_W*DIGITS-1:0] lap_digits_q;
  logic [BCD_W*DIGITS-1:0] lap_digits_d;
  logic                    lap_valid_q;
  logic                    lap_valid_d;

  always_comb begin
    lap_digits_d = lap_digits_q;
    lap_valid_d  = lap_valid_q;
    if (clear) begin
      lap_digits_d = '0;
      lap_valid_d  = 1'b0;
    end else if (lap && ((state_q == RUN) || (state_q == IDLE))) begin
      lap_digits_d = digits;
      lap_valid_d  = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      lap_digits_q <= '0;
      lap_valid_q  <= 1'b0;
    end else begin
      lap_digits_q <= lap_digits_d;
      lap_valid_q  <= lap_valid_d;
    end
  end

  assign lap_digits = lap_digits_q;
  assign lap_valid  = lap_valid_q;
`endif

endmodule

// File: tb/tb_bcd_timer_core.sv
// -----------------------------------------------------------------------------
// tb_bcd_timer_core
// Directed-vector bench for bcd_timer_core with DIGITS=4 and a widened
// adj_sel (SELW=3) so that an out-of-range digit index can be driven.
// Covers LAP_EN when that macro is defined.
// -----------------------------------------------------------------------------
module tb_bcd_timer_core;

  localparam int DIGITS = 4;
  localparam int SELW   = 3;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                tick = 1'b0;
  logic                run_toggle = 1'b0;
  logic                clear = 1'b0;
  logic                down = 1'b0;
  logic                adj = 1'b0;
  logic [SELW-1:0]     adj_sel = '0;
  logic [3:0]          adj_val = '0;
  logic                adj_load = 1'b0;
  logic [4*DIGITS-1:0] digits;
  logic                running;
  logic                expired;
  logic                wrap;
`ifdef LAP_EN
  logic                lap = 1'b0;
  logic [4*DIGITS-1:0] lap_digits;
  logic                lap_valid;
`endif

  int vec_cnt = 0;
  int err_cnt = 0;

  always #5 clk = ~clk;

  bcd_timer_core #(
    .DIGITS(DIGITS),
    .SELW  (SELW)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .run_toggle(run_toggle),
    .clear     (clear),
    .down      (down),
    .adj       (adj),
    .adj_sel   (adj_sel),
    .adj_val   (adj_val),
    .adj_load  (adj_load),
`ifdef LAP_EN
    .lap       (lap),
    .lap_digits(lap_digits),
    .lap_valid (lap_valid),
`endif
    .digits    (digits),
    .running   (running),
    .expired   (expired),
    .wrap      (wrap)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%0h", tag, got);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_toggle();
    run_toggle = 1'b1;
    step();
    run_toggle = 1'b0;
  endtask

  task automatic adj_write(input logic [SELW-1:0] sel, input logic [3:0] val);
    adj_sel  = sel;
    adj_val  = val;
    adj_load = 1'b1;
    step();
    adj_load = 1'b0;
  endtask

  initial begin
    // Reset
    step();
    step();
    rst = 1'b0;
    check_vec("rst_digits", 32'(digits), 32'h0000);
    check_vec("rst_running", 32'(running), 32'd0);
    check_vec("rst_expired", 32'(expired), 32'd0);
    check_vec("rst_wrap", 32'(wrap), 32'd0);

    // Up count: 61 ticks -> 01:01
    pulse_toggle();
    check_vec("start_running", 32'(running), 32'd1);
    tick = 1'b1;
    repeat (61) step();
    tick = 1'b0;
    check_vec("up61_digits", 32'(digits), 32'h0101);
    check_vec("up61_running", 32'(running), 32'd1);

    // Load 59:59 and roll over
    adj = 1'b1;
    step();
    check_vec("adj_running", 32'(running), 32'd0);
    adj_write(3'd0, 4'd9);
    adj_write(3'd1, 4'd5);
    adj_write(3'd2, 4'd9);
    adj_write(3'd3, 4'd5);
    check_vec("load_5959", 32'(digits), 32'h5959);
    adj = 1'b0;
    step();
    pulse_toggle();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_vec("wrap_digits", 32'(digits), 32'h0000);
    check_vec("wrap_pulse", 32'(wrap), 32'd1);
    check_vec("wrap_running", 32'(running), 32'd1);
    step();
    check_vec("wrap_one_cycle", 32'(wrap), 32'd0);

    // Count down from 00:02 to expiry
    pulse_toggle();
    adj = 1'b1;
    step();
    adj_write(3'd0, 4'd2);
    adj = 1'b0;
    step();
    down = 1'b1;
    pulse_toggle();
    check_vec("down_running", 32'(running), 32'd1);
    tick = 1'b1;
    step();
    check_vec("down_0001", 32'(digits), 32'h0001);
    step();
    check_vec("down_0000", 32'(digits), 32'h0000);
    check_vec("expired_set", 32'(expired), 32'd1);
    check_vec("expired_running", 32'(running), 32'd0);
    repeat (3) step();
    tick = 1'b0;
    check_vec("expired_hold_digits", 32'(digits), 32'h0000);
    check_vec("expired_sticky", 32'(expired), 32'd1);
    pulse_toggle();
    check_vec("expired_ack", 32'(expired), 32'd0);
    check_vec("expired_ack_running", 32'(running), 32'd0);
    pulse_toggle();
    check_vec("zero_down_no_start", 32'(running), 32'd0);
    down = 1'b0;

    // ADJUST: clear stays in ADJUST, clamping, out-of-range select
    adj = 1'b1;
    step();
    adj_write(3'd2, 4'd3);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_vec("adj_clear", 32'(digits), 32'h0000);
    adj_write(3'd1, 4'd9);
    check_vec("adj_clamp_tens", 32'(digits), 32'h0050);
    adj_write(3'd0, 4'd7);
    check_vec("adj_units", 32'(digits), 32'h0057);
    adj_write(3'd4, 4'd3);
    check_vec("adj_sel_oob", 32'(digits), 32'h0057);
    adj_write(3'd3, 4'd8);
    check_vec("adj_clamp_top", 32'(digits), 32'h5057);

    // Same-cycle tick and run_toggle in RUN at 00:10
    clear = 1'b1;
    step();
    clear = 1'b0;
    adj_write(3'd1, 4'd1);
    adj = 1'b0;
    step();
    pulse_toggle();
    check_vec("run_0010", 32'(running), 32'd1);
    tick = 1'b1;
    run_toggle = 1'b1;
    step();
    run_toggle = 1'b0;
    check_vec("tick_toggle_digits", 32'(digits), 32'h0011);
    check_vec("tick_toggle_paused", 32'(running), 32'd0);
    step();
    tick = 1'b0;
    check_vec("idle_tick_ignored", 32'(digits), 32'h0011);

    // rst wins over clear and tick
    pulse_toggle();
    rst = 1'b1;
    clear = 1'b1;
    tick = 1'b1;
    step();
    rst = 1'b0;
    clear = 1'b0;
    tick = 1'b0;
    check_vec("rst_prio_digits", 32'(digits), 32'h0000);
    check_vec("rst_prio_running", 32'(running), 32'd0);
    check_vec("rst_prio_wrap", 32'(wrap), 32'd0);

    // Down borrow across the minutes boundary: 01:00 -> 00:59
    adj = 1'b1;
    step();
    adj_write(3'd2, 4'd1);
    adj = 1'b0;
    step();
    down = 1'b1;
    pulse_toggle();
    tick = 1'b1;
    step();
    tick = 1'b0;
    check_vec("borrow_0059", 32'(digits), 32'h0059);
    clear = 1'b1;
    step();
    clear = 1'b0;
    down = 1'b0;
    check_vec("clear_digits", 32'(digits), 32'h0000);
    check_vec("clear_running", 32'(running), 32'd0);

`ifdef LAP_EN
    // Lap capture with a coincident tick at 00:05
    adj = 1'b1;
    step();
    adj_write(3'd0, 4'd5);
    adj = 1'b0;
    step();
    pulse_toggle();
    tick = 1'b1;
    lap = 1'b1;
    step();
    tick = 1'b0;
    lap = 1'b0;
    check_vec("lap_digits", 32'(lap_digits), 32'h0005);
    check_vec("lap_live_digits", 32'(digits), 32'h0006);
    check_vec("lap_valid", 32'(lap_valid), 32'd1);
    clear = 1'b1;
    step();
    clear = 1'b0;
    check_vec("lap_valid_clr", 32'(lap_valid), 32'd0);
    check_vec("lap_digits_clr", 32'(lap_digits), 32'h0000);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
